time_surface_scanner: RTL and testbench
=======================================

Name: time_surface_scanner

Overview:
- Read-side engine for the 256x16 per-pixel timestamp store; drives the read-only scan port (address out, 16-bit data in, 1-cycle synchronous read latency).
- On each start it sweeps all 256 pixel addresses and converts each stored timestamp into a quantised linear-decay feature relative to a snapshot of the current time.
- Emits one feature per pixel on a valid/ready stream feeding the gesture classifier's feature stage.

Parameters:
- TS_W, 16, timestamp width; matches the store word width.
- ADDR_W, 8, pixel address width; depth is 2**ADDR_W = 256.
- WINDOW_LOG2, 12, decay window is 2**WINDOW_LOG2 ticks (4096).
- FEAT_W, 4, feature width; must satisfy FEAT_W <= WINDOW_LOG2.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle scan request; ignored while busy.
- now_ts  in  TS_W  current time; sampled only on an accepted start.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse the cycle after the last feature handshake.
- bram_addr  out  ADDR_W  scan-port read address.
- bram_dout  in  TS_W  scan-port read data for the address presented the previous cycle.
- feat_valid  out  1  feature word valid.
- feat_ready  in  1  downstream accept.
- feat_data  out  FEAT_W  quantised feature.
- feat_addr  out  ADDR_W  pixel index of feat_data.
- feat_last  out  1  high with the feature for address 255.

Behaviour:
- Reset values: busy=0, done=0, feat_valid=0, feat_last=0, feat_data=0, feat_addr=0, bram_addr=0; FSM in IDLE.
- FSM states:
  - IDLE: on start, latch now_ts into now_q, set bram_addr=0, go to PRIME.
  - PRIME: one cycle, bram_addr advances to 1; data for address 0 arrives. Go to STREAM.
  - STREAM: see stream rules below.
  - DONE: assert done for one cycle, clear busy, go to IDLE.
- STREAM rules:
  - Load condition: !feat_valid || feat_ready.
  - On load: output register takes the feature computed from bram_dout, feat_addr = bram_addr-1, and bram_addr increments.
  - No load: bram_addr holds, so bram_dout stays valid for the held address.
  - Throughput: one feature per cycle with ready held high; first feat_valid 2 cycles after start.
  - After the address-255 load, bram_addr stops incrementing (no wrap). Go to DONE on the handshake of feat_last.
- Feature arithmetic:
  - age = now_q - ts, modulo 2**TS_W; unsigned wrap is intended, so timestamps across a counter wrap are handled.
  - If ts == 0 or age >= 2**WINDOW_LOG2: feature = 0. Timestamp 0 is reserved for "never written"; the writer maps time 0 to 1.
  - Otherwise: feature = (2**WINDOW_LOG2 - 1 - age) >> (WINDOW_LOG2 - FEAT_W). Age 0 gives the maximum value (15 at defaults).
- Output stability: feat_data, feat_addr and feat_last are stable while feat_valid && !feat_ready.
- Concurrent writes on the event port during a scan are permitted. Each pixel reflects the store contents at its read cycle; no frame consistency is guaranteed.
- start while busy is ignored. start in the same cycle as done's IDLE return is accepted only once the FSM is back in IDLE.
- rst mid-scan: immediate return to IDLE with all outputs at reset values; no done pulse.

Optional Feature:
- Macro: TS_SCAN_STATS_EN.
- With it: adds output active_count (ADDR_W+1 bits), which counts features != 0 in the current scan. It is cleared on accepted start, incremented on each handshake with nonzero feat_data, and held after done until the next start.
- Without it: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package: TS_W, ADDR_W, the pixel count, the reserved empty-timestamp constant 0, and the scan FSM state enum.
- One natural sub-module, ts_decay_quant: combinational age/threshold/shift from (now_q, ts) to feature, reused by any future per-pixel readers.

Test Plan:
- Memory all zeros, start with now_ts=1000, feat_ready=1 -> 256 features all 0; feat_last on addr 255; done 1 cycle after; 258 cycles from start to done.
- mem[5]=1000, now_ts=1000 -> feat_addr 5 gives 15. mem[6]=1000-4095 (mod 2**16) gives 0 at age 4095. mem[7]=1000-4096 gives 0. mem[8]=1000-256 gives 14.
- Wrap: mem[3]=65530, now_ts=10 (age 16) -> feature 15.
- Random feat_ready backpressure, 30% duty -> feat_addr sequence 0..255 gapless, in order; data stable during stalls; feature values match the model.
- Assert rst when feat_addr=100 -> next cycle feat_valid=0, busy=0, no done; a new start scans from address 0.
- start pulses while busy ignored. With TS_SCAN_STATS_EN: three nonzero pixels -> active_count=3 after done.

Source files
------------

// File: rtl/time_surface_scanner_pkg.sv
// Shared constants and scan FSM state type for the time-surface scanner.
package time_surface_scanner_pkg;

  localparam int TS_W        = 16;
  localparam int ADDR_W      = 8;
  localparam int PIX_COUNT   = 2 ** ADDR_W;
  localparam int WINDOW_LOG2 = 12;
  localparam int FEAT_W      = 4;

  // A stored timestamp of zero means the pixel has never been written.
  localparam logic [TS_W-1:0] TS_EMPTY = '0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRIME,
    S_STREAM,
    S_DONE
  } scan_state_e;

endpackage

// File: rtl/ts_decay_quant.sv
// Combinational linear-decay quantiser: (reference time, timestamp) -> feature.
module ts_decay_quant
  import time_surface_scanner_pkg::*;
#(
  parameter int Q_TS_W        = TS_W,
  parameter int Q_WINDOW_LOG2 = WINDOW_LOG2,
  parameter int Q_FEAT_W      = FEAT_W
) (
  input  logic [Q_TS_W-1:0]   ref_ts,
  input  logic [Q_TS_W-1:0]   ts,
  output logic [Q_FEAT_W-1:0] feat
);

  localparam logic [Q_TS_W-1:0] WINDOW = Q_TS_W'(1) << Q_WINDOW_LOG2;

  logic [Q_TS_W-1:0]      age;
  logic [Q_WINDOW_LOG2-1:0] remain;

  // Modular subtraction keeps ages correct across a timestamp counter wrap.
  assign age = ref_ts - ts;

  // Inside the window, (2**W - 1 - age) is the bitwise inverse of the low W bits.
  assign remain = ~age[Q_WINDOW_LOG2-1:0];

  always_comb begin
    feat = '0;
    if (ts != Q_TS_W'(TS_EMPTY) && age < WINDOW) begin
      feat = Q_FEAT_W'(remain >> (Q_WINDOW_LOG2 - Q_FEAT_W));
    end
  end

endmodule

// File: rtl/time_surface_scanner.sv
// Sweeps the 256x16 timestamp store and streams one decay feature per pixel.
// Optional TS_SCAN_STATS_EN adds active_count (nonzero features in the current scan).
module time_surface_scanner
  import time_surface_scanner_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [TS_W-1:0]   now_ts,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] bram_addr,
  input  logic [TS_W-1:0]   bram_dout,
  output logic              feat_valid,
  input  logic              feat_ready,
  output logic [FEAT_W-1:0] feat_data,
  output logic [ADDR_W-1:0] feat_addr,
  output logic              feat_last
`ifdef TS_SCAN_STATS_EN
  ,
  output logic [ADDR_W:0]   active_count
`endif
);

  localparam logic [ADDR_W-1:0] PIX_LAST = ADDR_W'(PIX_COUNT - 1);

  scan_state_e       state, state_next;
  logic [TS_W-1:0]   now_q;
  logic [ADDR_W-1:0] next_pix;
  logic              all_loaded;
  logic              fresh;
  logic [TS_W-1:0]   held_ts;
  logic [TS_W-1:0]   src_ts;
  logic [FEAT_W-1:0] feat_calc;
  logic              load;
  logic              fire;

  assign fire = feat_valid && feat_ready;
  assign load = (state == S_STREAM) && !all_loaded && (!feat_valid || feat_ready);

  // While bram_addr is held the store output moves on to the held address, so the
  // word belonging to next_pix is kept in held_ts from the first stalled cycle.
  assign src_ts = fresh ? bram_dout : held_ts;

  ts_decay_quant u_quant (
    .ref_ts (now_q),
    .ts     (src_ts),
    .feat   (feat_calc)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE:   if (start) state_next = S_PRIME;
      S_PRIME: begin
        busy       = 1'b1;
        state_next = S_STREAM;
      end
      S_STREAM: begin
        busy = 1'b1;
        if (fire && feat_last) state_next = S_DONE;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      now_q      <= '0;
      bram_addr  <= '0;
      next_pix   <= '0;
      all_loaded <= 1'b0;
      fresh      <= 1'b0;
      held_ts    <= '0;
      feat_valid <= 1'b0;
      feat_data  <= '0;
      feat_addr  <= '0;
      feat_last  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            now_q      <= now_ts;
            bram_addr  <= '0;
            next_pix   <= '0;
            all_loaded <= 1'b0;
            fresh      <= 1'b0;
          end
        end
        S_PRIME: begin
          bram_addr <= ADDR_W'(1);
          fresh     <= 1'b1;
        end
        S_STREAM: begin
          fresh <= load;
          if (fresh) held_ts <= bram_dout;
          if (load) begin
            feat_valid <= 1'b1;
            feat_data  <= feat_calc;
            feat_addr  <= next_pix;
            feat_last  <= (next_pix == PIX_LAST);
            next_pix   <= next_pix + ADDR_W'(1);
            if (next_pix == PIX_LAST) all_loaded <= 1'b1;
            if (bram_addr != PIX_LAST) bram_addr <= bram_addr + ADDR_W'(1);
          end else if (fire) begin
            feat_valid <= 1'b0;
            feat_last  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef TS_SCAN_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      active_count <= '0;
    end else if (state == S_IDLE && start) begin
      active_count <= '0;
    end else if (fire && feat_data != '0) begin
      active_count <= active_count + (ADDR_W+1)'(1);
    end
  end
`endif

endmodule

// File: tb/tb_time_surface_scanner.sv
// Randomised self-checking bench for time_surface_scanner against a decay-feature model.
`timescale 1ns/1ps
module tb_time_surface_scanner;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] now_ts;
  logic        busy;
  logic        done;
  logic [7:0]  bram_addr;
  logic [15:0] bram_dout;
  logic        feat_valid;
  logic        feat_ready;
  logic [3:0]  feat_data;
  logic [7:0]  feat_addr;
  logic        feat_last;
`ifdef TS_SCAN_STATS_EN
  logic [8:0]  active_count;
`endif

  logic [15:0] mem [256];
  int          got_feat [256];
  int          vectors;
  int          miscompares;
  int          last_nz;

  time_surface_scanner dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .now_ts     (now_ts),
    .busy       (busy),
    .done       (done),
    .bram_addr  (bram_addr),
    .bram_dout  (bram_dout),
    .feat_valid (feat_valid),
    .feat_ready (feat_ready),
    .feat_data  (feat_data),
    .feat_addr  (feat_addr),
    .feat_last  (feat_last)
`ifdef TS_SCAN_STATS_EN
    ,
    .active_count (active_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Timestamp store model: one-cycle synchronous read.
  always @(posedge clk) bram_dout <= mem[bram_addr];

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic int refFeature(input int now, input int ts);
    int age;
    age = (now - ts) & 'hFFFF;
    if (ts == 0 || age >= 4096) return 0;
    return (4095 - age) / 256;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One full scan from a start pulse; checks every handshake and the done timing.
  task automatic applyStimulus(input int now, input int duty, input bit poke_start);
    int   exp_idx;
    int   edges;
    int   first_valid;
    int   nz;
    int   exp_feat;
    bit   seen_done;
    bit   stalled;
    logic [3:0] h_data;
    logic [7:0] h_addr;
    logic       h_last;
    exp_idx = 0; edges = 0; first_valid = -1; nz = 0;
    seen_done = 0; stalled = 0; h_data = '0; h_addr = '0; h_last = 0;
    start  = 1'b1;
    now_ts = 16'(now);
    @(negedge clk);
    start  = 1'b0;
    now_ts = 16'($urandom);
    while (!seen_done && edges < 4000) begin
      if (done) begin
        seen_done = 1;
        start     = 1'b0;
        checkOutput("pixels_before_done", exp_idx, 256);
        checkOutput("busy_at_done", busy, 0);
        if (duty == 100) checkOutput("start_to_done_cycles", edges, 258);
      end else begin
        if (feat_valid && first_valid < 0) begin
          first_valid = edges;
          checkOutput("first_valid_latency", edges, 2);
        end
        checkOutput("busy_during_scan", busy, 1);
        if (stalled) begin
          checkOutput("stall_valid", feat_valid, 1);
          checkOutput("stall_data", feat_data, h_data);
          checkOutput("stall_addr", feat_addr, h_addr);
          checkOutput("stall_last", feat_last, h_last);
        end
        start      = poke_start && ($urandom_range(9) == 0);
        now_ts     = 16'($urandom);
        feat_ready = ($urandom_range(99) < duty);
        if (feat_valid && feat_ready) begin
          exp_feat = refFeature(now, mem[exp_idx & 255]);
          checkOutput("feat_addr", feat_addr, exp_idx);
          checkOutput("feat_data", feat_data, exp_feat);
          checkOutput("feat_last", feat_last, (exp_idx == 255));
          got_feat[exp_idx & 255] = feat_data;
          if (exp_feat != 0) nz++;
          exp_idx++;
        end
        stalled = feat_valid && !feat_ready;
        h_data  = feat_data;
        h_addr  = feat_addr;
        h_last  = feat_last;
      end
      @(negedge clk);
      edges++;
    end
    start = 1'b0;
    if (!seen_done) checkOutput("scan_timeout", 0, 1);
    checkOutput("done_single_pulse", done, 0);
    last_nz = nz;
`ifdef TS_SCAN_STATS_EN
    checkOutput("active_count", active_count, nz);
`endif
  endtask

  initial begin
    int now;
    int edges;
    vectors = 0; miscompares = 0; last_nz = 0;
    rst = 1'b1; start = 1'b0; feat_ready = 1'b0; now_ts = '0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = '0;
      got_feat[i] = -1;
    end
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_valid", feat_valid, 0);
    checkOutput("rst_last", feat_last, 0);
    checkOutput("rst_data", feat_data, 0);
    checkOutput("rst_faddr", feat_addr, 0);
    checkOutput("rst_baddr", bram_addr, 0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] empty store scan");
    applyStimulus(1000, 100, 0);
    checkOutput("empty_nz", last_nz, 0);

    $display("[TB] window boundary scan");
    mem[5] = 16'd1000;
    mem[6] = 16'(1000 - 4095);
    mem[7] = 16'(1000 - 4096);
    mem[8] = 16'(1000 - 256);
    mem[9] = 16'd999;
    applyStimulus(1000, 100, 0);
    checkOutput("age0_feat", got_feat[5], 15);
    checkOutput("age4095_feat", got_feat[6], 0);
    checkOutput("age4096_feat", got_feat[7], 0);
    checkOutput("age256_feat", got_feat[8], 14);
    checkOutput("age1_feat", got_feat[9], 15);
`ifdef TS_SCAN_STATS_EN
    checkOutput("three_active", active_count, 3);
`endif

    $display("[TB] counter wrap scan");
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[3] = 16'd65530;
    applyStimulus(10, 100, 0);
    checkOutput("wrap_feat", got_feat[3], 15);

    $display("[TB] random store with 30 percent ready");
    now = $urandom_range(65535);
    for (int i = 0; i < 256; i++)
      mem[i] = ($urandom_range(3) == 0) ? 16'd0 : 16'(now - $urandom_range(5000));
    applyStimulus(now, 30, 1);

    $display("[TB] reset in the middle of a scan");
    feat_ready = 1'b1;
    start      = 1'b1;
    now_ts     = 16'd500;
    @(negedge clk);
    start = 1'b0;
    edges = 0;
    while (!(feat_valid && feat_addr == 8'd100) && edges < 400) begin
      @(negedge clk);
      edges++;
    end
    checkOutput("reached_addr100", feat_addr, 100);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_valid", feat_valid, 0);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_done", done, 0);
    checkOutput("midrst_baddr", bram_addr, 0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("no_done_after_rst", done, 0);
    end

    $display("[TB] random rescan after reset");
    now = $urandom_range(65535);
    for (int i = 0; i < 256; i++)
      mem[i] = ($urandom_range(2) == 0) ? 16'd0 : 16'(now - $urandom_range(4500));
    applyStimulus(now, 70, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
